// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bus unit: region decode, FSM states and the
// interrupt register offsets.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IRQ,
        REG_IO
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        MEM_RD,
        IO_WAIT,
        DONE
    } state_e;

    localparam int IRQ_PEND_OFS = 0;
    localparam int IRQ_EN_OFS   = 1;

endpackage

// File: rtl/cpu_bus_unit_irq_ctrl.sv
// Interrupt controller: rising-edge detect on level sources, W1C pending
// register, read/write enable register, registered irq_out and read mux.
module irq_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               reg_wr,
    input  logic [WIDTH-1:0]   reg_ofs,
    input  logic [NUM_IRQ-1:0] reg_wdata,
    output logic [WIDTH-1:0]   reg_rdata,
    output logic               irq_out
);

    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] pend_clr;
    logic               irq_out_q, irq_out_d;

    // Next-state for the interrupt registers; a new edge beats a same-cycle clear.
    always_comb begin
        pend_clr = '0;
        en_d     = en_q;
        if (reg_wr && reg_ofs == WIDTH'(IRQ_PEND_OFS)) begin
            pend_clr = reg_wdata;
        end
        if (reg_wr && reg_ofs == WIDTH'(IRQ_EN_OFS)) begin
            en_d = reg_wdata;
        end
        pend_d    = (pend_q & ~pend_clr) | (irq_in & ~prev_q);
        prev_d    = irq_in;
        irq_out_d = |(pend_q & en_q);
    end

    // Register read mux; unimplemented offsets and upper bits read as zero.
    always_comb begin
        reg_rdata = '0;
        if (reg_ofs == WIDTH'(IRQ_PEND_OFS)) begin
            reg_rdata[NUM_IRQ-1:0] = pend_q;
        end else if (reg_ofs == WIDTH'(IRQ_EN_OFS)) begin
            reg_rdata[NUM_IRQ-1:0] = en_q;
        end
    end

    // Interrupt state flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            irq_out_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            irq_out_q <= irq_out_d;
        end
    end

    assign irq_out = irq_out_q;

endmodule

// File: rtl/cpu_bus_unit.sv
// CPU bus unit: decodes each request into RAM, interrupt registers or IO
// and completes it with a one-cycle cpu_ready pulse.
//
// state   | meaning
// IDLE    | waiting for a new request (ignored in the cycle cpu_ready is high)
// MEM_RD  | RAM read issued, counting down the read latency
// IO_WAIT | io_req held, waiting for io_ack or the timeout
// DONE    | access finished; next cycle pulses cpu_ready (and bus_err on timeout)
module cpu_bus_unit
    import cpu_bus_pkg::*;
#(
    parameter int               WIDTH             = 16,
    parameter int               NUM_IRQ           = 4,
    parameter logic [WIDTH-1:0] INTERRUPT_CONTROL = 16'h5FFF,
    parameter logic [WIDTH-1:0] DATA_STACK        = 16'h6FFE,
    parameter logic [WIDTH-1:0] IO_MEM            = 16'hCFFD,
    parameter int               MEM_LAT           = 1,
    parameter int               IO_TIMEOUT        = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [WIDTH-1:0]   cpu_adr,
    input  logic [WIDTH-1:0]   cpu_wdata,
    output logic [WIDTH-1:0]   cpu_rdata,
    output logic               cpu_ready,
    output logic               bus_err,
    output logic [WIDTH-1:0]   mem_adr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               mem_we,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               io_req,
    output logic               io_we,
    output logic [WIDTH-1:0]   io_adr,
    output logic [WIDTH-1:0]   io_wdata,
    input  logic [WIDTH-1:0]   io_rdata,
    input  logic               io_ack,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    localparam int CNT_MAX = (MEM_LAT > IO_TIMEOUT) ? MEM_LAT : IO_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               bus_err_q, bus_err_d;
    logic [WIDTH-1:0]   mem_adr_q, mem_adr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               io_req_q, io_req_d;
    logic               io_we_q, io_we_d;
    logic [WIDTH-1:0]   io_adr_q, io_adr_d;
    logic [WIDTH-1:0]   io_wdata_q, io_wdata_d;

    region_e            region;
    logic               accept;
    logic               irq_wr;
    logic [WIDTH-1:0]   irq_ofs;
    logic [WIDTH-1:0]   irq_rdata;

    // Address decode; the upper RAM window sits between the interrupt block and IO.
    always_comb begin
        if (cpu_adr < INTERRUPT_CONTROL) begin
            region = REG_RAM;
        end else if (cpu_adr < DATA_STACK) begin
            region = REG_IRQ;
        end else if (cpu_adr < IO_MEM) begin
            region = REG_RAM;
        end else begin
            region = REG_IO;
        end
    end

    assign accept  = (state_q == IDLE) && cpu_req && !cpu_ready_q;
    assign irq_wr  = accept && (region == REG_IRQ) && cpu_we;
    assign irq_ofs = cpu_adr - INTERRUPT_CONTROL;

    irq_ctrl #(
        .WIDTH   (WIDTH),
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_ctrl (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .reg_wr    (irq_wr),
        .reg_ofs   (irq_ofs),
        .reg_wdata (cpu_wdata[NUM_IRQ-1:0]),
        .reg_rdata (irq_rdata),
        .irq_out   (irq_out)
    );

    // FSM next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        bus_err_d   = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        io_req_d    = io_req_q;
        io_we_d     = io_we_q;
        io_adr_d    = io_adr_q;
        io_wdata_d  = io_wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (region)
                        REG_RAM: begin
                            mem_adr_d = cpu_adr;
                            if (cpu_we) begin
                                mem_wdata_d = cpu_wdata;
                                mem_we_d    = 1'b1;
                                state_d     = DONE;
                            end else begin
                                cnt_d   = CNT_W'(MEM_LAT);
                                state_d = MEM_RD;
                            end
                        end
                        REG_IRQ: begin
                            if (!cpu_we) begin
                                cpu_rdata_d = irq_rdata;
                            end
                            state_d = DONE;
                        end
                        default: begin
                            io_req_d   = 1'b1;
                            io_we_d    = cpu_we;
                            io_adr_d   = cpu_adr - IO_MEM;
                            io_wdata_d = cpu_wdata;
                            cnt_d      = CNT_W'(IO_TIMEOUT);
                            state_d    = IO_WAIT;
                        end
                    endcase
                end
            end
            MEM_RD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    cpu_rdata_d = mem_rdata;
                    state_d     = DONE;
                end
            end
            IO_WAIT: begin
                if (io_ack) begin
                    if (!io_we_q) begin
                        cpu_rdata_d = io_rdata;
                    end
                    io_req_d = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_W'(1)) begin
                    cpu_rdata_d = '1;
                    io_req_d    = 1'b0;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                cpu_ready_d = 1'b1;
                bus_err_d   = err_q;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            io_req_q    <= 1'b0;
            io_we_q     <= 1'b0;
            io_adr_q    <= '0;
            io_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            bus_err_q   <= bus_err_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            io_req_q    <= io_req_d;
            io_we_q     <= io_we_d;
            io_adr_q    <= io_adr_d;
            io_wdata_q  <= io_wdata_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign bus_err   = bus_err_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign io_req    = io_req_q;
    assign io_we     = io_we_q;
    assign io_adr    = io_adr_q;
    assign io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Directed bench for cpu_bus_unit with MEM_LAT=2 and IO_TIMEOUT=15.
module tb_cpu_bus_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        bus_err;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        io_req;
    logic        io_we;
    logic [15:0] io_adr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_ack;
    logic [3:0]  irq_in;
    logic        irq_out;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] mem_arr [256];
    int          n_mem_we = 0;
    logic [15:0] last_mem_adr = '0;
    int          n_io_cyc = 0;
    logic [15:0] last_io_adr = '1;
    int          io_wait = 0;
    int          ack_delay = 0;

    cpu_bus_unit #(
        .WIDTH      (16),
        .NUM_IRQ    (4),
        .MEM_LAT    (2),
        .IO_TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .bus_err   (bus_err),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_adr    (io_adr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack),
        .irq_in    (irq_in),
        .irq_out   (irq_out)
    );

    always #5 clk = ~clk;

    // RAM model with combinational read and monitors for strobes.
    assign mem_rdata = mem_arr[mem_adr[7:0]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_adr[7:0]] <= mem_wdata;
            n_mem_we     <= n_mem_we + 1;
            last_mem_adr <= mem_adr;
        end
        if (io_req) begin
            n_io_cyc    <= n_io_cyc + 1;
            last_io_adr <= io_adr;
        end
        io_wait <= io_req ? io_wait + 1 : 0;
    end

    // IO responder: ack is sampled ack_delay edges after accept; 0 = never.
    assign io_ack = io_req && (ack_delay != 0) && (io_wait == ack_delay - 1);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One CPU access; lat counts edges from accept to the edge that samples cpu_ready.
    task automatic do_acc(input logic we, input logic [15:0] adr, input logic [15:0] wd,
                          output logic [15:0] rd, output logic err, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        rd   = '0;
        err  = 1'b0;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_adr   = adr;
        cpu_wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) begin
                seen = 1'b1;
                lat  = k + 1;
                rd   = cpu_rdata;
                err  = bus_err;
            end
        end
        chk("ready_seen", 32'(seen), 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_pulse", 32'(cpu_ready), 32'd0);
    endtask

    logic [15:0] rd;
    logic        err;
    int          lat;
    int          base_we;
    int          base_io;
    int          n_rdy;

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_adr   = '0;
        cpu_wdata = '0;
        io_rdata  = '0;
        irq_in    = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  32'(cpu_ready), 32'd0);
        chk("rst_err",    32'(bus_err),   32'd0);
        chk("rst_mem_we", 32'(mem_we),    32'd0);
        chk("rst_io_req", 32'(io_req),    32'd0);
        chk("rst_irq",    32'(irq_out),   32'd0);
        chk("rst_rdata",  32'(cpu_rdata), 32'd0);
        chk("rst_madr",   32'(mem_adr),   32'd0);
        chk("rst_ioadr",  32'(io_adr),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // RAM write then read
        do_acc(1'b1, 16'h0010, 16'hBEEF, rd, err, lat);
        chk("wr_lat",    32'(lat),          32'd2);
        chk("wr_strobe", 32'(n_mem_we),     32'd1);
        chk("wr_adr",    32'(last_mem_adr), 32'h0010);
        do_acc(1'b0, 16'h0010, 16'h0000, rd, err, lat);
        chk("rd_lat",    32'(lat),       32'd4);
        chk("rd_data",   32'(rd),        32'hBEEF);
        chk("rd_nowe",   32'(n_mem_we),  32'd1);
        chk("rd_hold",   32'(cpu_rdata), 32'hBEEF);

        // Region boundaries
        ack_delay = 1;
        base_we = n_mem_we; base_io = n_io_cyc;
        do_acc(1'b1, 16'h5FFE, 16'h1111, rd, err, lat);
        chk("b5ffe_we",  32'(n_mem_we - base_we), 32'd1);
        chk("b5ffe_adr", 32'(last_mem_adr),       32'h5FFE);
        chk("b5ffe_io",  32'(n_io_cyc - base_io), 32'd0);
        base_we = n_mem_we;
        do_acc(1'b1, 16'h5FFF, 16'h0000, rd, err, lat);
        chk("b5fff_we",  32'(n_mem_we - base_we), 32'd0);
        chk("b5fff_io",  32'(n_io_cyc - base_io), 32'd0);
        chk("irq_lat",   32'(lat),                32'd2);
        do_acc(1'b1, 16'h6FFE, 16'h2222, rd, err, lat);
        chk("b6ffe_we",  32'(n_mem_we - base_we), 32'd1);
        chk("b6ffe_adr", 32'(last_mem_adr),       32'h6FFE);
        base_we = n_mem_we;
        do_acc(1'b1, 16'hCFFD, 16'h3333, rd, err, lat);
        chk("bcffd_we",  32'(n_mem_we - base_we), 32'd0);
        chk("bcffd_io",  32'(n_io_cyc - base_io), 32'd1);
        chk("bcffd_adr", 32'(last_io_adr),        32'h0000);
        chk("bcffd_lat", 32'(lat),                32'd3);

        // IO ack after 3 cycles, timeout, and ack on the expiry cycle
        ack_delay = 3; io_rdata = 16'h1234;
        do_acc(1'b0, 16'hD000, 16'h0000, rd, err, lat);
        chk("io_data", 32'(rd),  32'h1234);
        chk("io_err",  32'(err), 32'd0);
        chk("io_lat",  32'(lat), 32'd5);
        ack_delay = 0;
        do_acc(1'b0, 16'hD000, 16'h0000, rd, err, lat);
        chk("to_data", 32'(rd),     32'hFFFF);
        chk("to_err",  32'(err),    32'd1);
        chk("to_lat",  32'(lat),    32'd17);
        chk("to_req",  32'(io_req), 32'd0);
        ack_delay = 15; io_rdata = 16'h5A5A;
        do_acc(1'b0, 16'hFFFF, 16'h0000, rd, err, lat);
        chk("edge_data", 32'(rd),  32'h5A5A);
        chk("edge_err",  32'(err), 32'd0);
        chk("edge_lat",  32'(lat), 32'd17);

        // Interrupt registers
        do_acc(1'b1, 16'h6000, 16'hFFFF, rd, err, lat);
        do_acc(1'b0, 16'h6000, 16'h0000, rd, err, lat);
        chk("en_mask", 32'(rd), 32'h000F);
        do_acc(1'b1, 16'h6000, 16'h0005, rd, err, lat);
        do_acc(1'b1, 16'h6001, 16'hFFFF, rd, err, lat);
        do_acc(1'b0, 16'h6001, 16'hFFFF, rd, err, lat);
        chk("ofs2_rd", 32'(rd), 32'h0000);
        irq_in = 4'b0011;
        repeat (2) @(posedge clk);
        #1;
        do_acc(1'b0, 16'h5FFF, 16'h0000, rd, err, lat);
        chk("pend_0011", 32'(rd),      32'h0003);
        chk("irq_hi",    32'(irq_out), 32'd1);
        do_acc(1'b1, 16'h5FFF, 16'h0001, rd, err, lat);
        chk("irq_lo",    32'(irq_out), 32'd0);
        do_acc(1'b0, 16'h5FFF, 16'h0000, rd, err, lat);
        chk("pend_0010", 32'(rd), 32'h0002);
        do_acc(1'b0, 16'h6000, 16'h0000, rd, err, lat);
        chk("en_0101",   32'(rd), 32'h0005);

        // New edge on bit 2 in the same cycle as its W1C
        irq_in[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        irq_in[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        irq_in[2] = 1'b1;
        do_acc(1'b1, 16'h5FFF, 16'h0004, rd, err, lat);
        do_acc(1'b0, 16'h5FFF, 16'h0000, rd, err, lat);
        chk("pend_race", 32'(rd), 32'h0006);

        // Reset during MEM_RD
        irq_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rmem_ready", 32'(cpu_ready), 32'd0);
        chk("rmem_ioreq", 32'(io_req),    32'd0);
        chk("rmem_irq",   32'(irq_out),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) n_rdy++;
        end
        chk("rmem_noready", 32'(n_rdy), 32'd0);
        do_acc(1'b0, 16'h5FFF, 16'h0000, rd, err, lat);
        chk("rmem_pend", 32'(rd),  32'h0000);
        chk("rmem_lat",  32'(lat), 32'd2);

        // Reset during IO_WAIT
        ack_delay = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'hD000;
        @(posedge clk);
        #1;
        chk("rio_req_up", 32'(io_req), 32'd1);
        chk("rio_adr",    32'(io_adr), 32'h0003);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rio_req_dn", 32'(io_req),    32'd0);
        chk("rio_ready",  32'(cpu_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) n_rdy++;
        end
        chk("rio_noready", 32'(n_rdy), 32'd0);
        do_acc(1'b0, 16'h6000, 16'h0000, rd, err, lat);
        chk("rio_en", 32'(rd), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_bus_unit.md
Name: cpu_bus_unit

Overview:
Parametrised memory/IO bus unit that sits between the arrozYleche control/datapath pair and the system memories. It replaces direct wiring of adr/memdata/memwrite with a request/ready handshake. Each CPU access is decoded into one of three regions:
- RAM, with configurable read latency.
- An internal interrupt-control register block with NUM_IRQ edge-detected channels.
- An external IO bus with an ack/timeout handshake.

The CPU control FSM stalls on cpu_ready.

Parameters:
WIDTH, 16, data and address width.
NUM_IRQ, 4, interrupt channel count (1..WIDTH).
INTERRUPT_CONTROL, 16'h5FFF, base address of the interrupt register block.
DATA_STACK, 16'h6FFE, base address of the upper RAM region; also the end of the interrupt region.
IO_MEM, 16'hCFFD, base address of the IO region; the region extends to the top of the address space.
MEM_LAT, 1, RAM read latency in cycles (>=1).
IO_TIMEOUT, 15, maximum cycles to wait for io_ack (>=1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cpu_req  in  1  access request; held high until cpu_ready
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_adr  in  WIDTH  byte/word address; stable while cpu_req is high
cpu_wdata  in  WIDTH  write data
cpu_rdata  out  WIDTH  read data; valid in the cycle cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
bus_err  out  1  one-cycle pulse together with cpu_ready on an IO timeout
mem_adr  out  WIDTH  RAM address
mem_wdata  out  WIDTH  RAM write data
mem_we  out  1  RAM write strobe (one cycle)
mem_rdata  in  WIDTH  RAM read data, valid MEM_LAT cycles after address issue
io_req  out  1  IO strobe, held until ack or timeout
io_we  out  1  IO write
io_adr  out  WIDTH  cpu_adr - IO_MEM
io_wdata  out  WIDTH  IO write data
io_rdata  in  WIDTH  IO read data, valid with io_ack
io_ack  in  1  IO completion
irq_in  in  NUM_IRQ  level interrupt sources
irq_out  out  1  |(pending & enable)

Behaviour:
- Reset (synchronous, active-high): the following outputs are 0 — cpu_rdata, cpu_ready, bus_err, mem_we, io_req, mem_adr, io_adr, irq_out. The pending register, the enable register and the previous-irq sample are 0. The FSM goes to IDLE. Reset mid-transaction aborts it immediately and no ready is issued.
- Region decode (unsigned compare on cpu_adr):
  - adr < INTERRUPT_CONTROL -> RAM.
  - INTERRUPT_CONTROL <= adr < DATA_STACK -> IRQ.
  - DATA_STACK <= adr < IO_MEM -> RAM.
  - adr >= IO_MEM -> IO.
- FSM states: IDLE, MEM_RD, IO_WAIT, DONE.
- IDLE with cpu_req=1, cpu_ready=0 (i.e. a new request, not the cycle after DONE):
  - RAM write: drive mem_adr/mem_wdata, mem_we=1 for one cycle -> DONE.
  - RAM read: drive mem_adr, load a counter with MEM_LAT -> MEM_RD.
  - IRQ read or write: perform the register access -> DONE.
  - IO: io_req=1, load the timeout counter with IO_TIMEOUT -> IO_WAIT.
- MEM_RD: decrement the counter. When it reaches 0, capture mem_rdata into cpu_rdata -> DONE.
- IO_WAIT:
  - io_ack=1: capture io_rdata (reads), drop io_req -> DONE.
  - Counter expires first: cpu_rdata = all ones, drop io_req, set the error flag -> DONE.
  - io_ack in the same cycle as expiry: the ack wins and no error is raised.
- DONE: cpu_ready=1 for exactly one cycle (bus_err=1 if the error flag is set) -> IDLE. The CPU must drop or replace cpu_req. The unit ignores cpu_req in the cycle DONE returns to IDLE, so there is no double issue.
- Latency, request accept to cpu_ready:
  - RAM write: 2 cycles.
  - IRQ access: 2 cycles.
  - RAM read: MEM_LAT + 2 cycles.
  - IO: (ack cycle - accept) + 2 cycles.
- IRQ registers, indexed by offset = cpu_adr - INTERRUPT_CONTROL:
  - Offset 0, PENDING: write-1-to-clear.
  - Offset 1, ENABLE: read/write.
  - Other offsets: read 0, writes ignored.
  - Register bits above NUM_IRQ read 0.
- IRQ edge detection: each cycle prev <= irq_in. Pending bit i is set when irq_in[i] & ~prev[i].
- Pending set vs clear: a new edge in the same cycle as a W1C of that bit leaves the bit set.
- irq_out is registered, so it has 1 cycle of latency from the pending/enable change.
- cpu_rdata holds its last value when cpu_ready=0.

Decomposition:
- Shared package cpu_bus_pkg: region enum (REG_RAM, REG_IRQ, REG_IO), FSM state typedef, IRQ register offsets (IRQ_PEND_OFS=0, IRQ_EN_OFS=1).
- One sub-module, irq_ctrl: edge detect, pending/enable registers, irq_out, and the register read mux. The FSM and decode stay in cpu_bus_unit.

Test Plan:
1. RAM write then read, MEM_LAT=2: write 16'hBEEF @16'h0010, then read @16'h0010 -> mem_we pulses once with mem_adr=16'h0010; the read's cpu_ready comes 4 cycles after accept with cpu_rdata=16'hBEEF.
2. Region boundaries: accesses @16'h5FFE (RAM), 16'h5FFF (IRQ, no mem_we), 16'h6FFE (RAM), 16'hCFFD (IO, io_adr=0) -> each strobes only its own region.
3. IO ack after 3 cycles with io_rdata=16'h1234 -> cpu_rdata=16'h1234 and bus_err=0. IO with no ack, IO_TIMEOUT=15 -> cpu_ready with cpu_rdata=16'hFFFF, bus_err=1, io_req low.
4. Interrupts: ENABLE=4'b0101, rising edge on irq_in[0] and irq_in[1] -> PENDING=4'b0011 and irq_out=1. W1C 4'b0001 -> PENDING=4'b0010, irq_out=0.
5. W1C of bit 2 in the same cycle as a new irq_in[2] edge -> PENDING[2] stays 1.
6. Reset asserted in MEM_RD and in IO_WAIT -> next cycle io_req=0, no cpu_ready, FSM in IDLE, PENDING=0.
